// File: rtl/pc_seq.sv
// pc_seq: picoMIPS instruction sequencer; classifies op_class, gates pcnt.inc and the regfile write strobe.
// Latency: single op retires in 1 cycle, multi op in MUL_CYCLES cycles, wait op in >= 2 cycles (RUN + WAIT).
// Backpressure: PC holds while busy (MULTI/WAIT), halted, or run_en low; WAIT holds until in_valid, acked by in_ack.
// Optional feature: define PC_WRAP_EN to let the PC wrap from all-ones to 0 instead of halting there.
module pc_seq #(
    parameter int PMEM_WIDTH = 5,
    parameter int MUL_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [PMEM_WIDTH-1:0] addr,
    input  logic [1:0]            op_class,
    input  logic                  run_en,
    input  logic                  in_valid,
    output logic                  in_ack,
    output logic                  inc,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  halted
);

    localparam int CNT_W = $clog2(MUL_CYCLES);
    // The RUN cycle counts as the first cycle and the retiring MULTI cycle as the last.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

    localparam logic [1:0] OP_SINGLE = 2'b00;
    localparam logic [1:0] OP_MULTI  = 2'b01;
    localparam logic [1:0] OP_WAIT   = 2'b10;
    localparam logic [1:0] OP_HALT   = 2'b11;

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_MULTI = 2'b01,
        S_WAIT  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic   retire;
    logic   ack_raw;
    logic   inc_raw;
    logic   at_end;
    state_t retire_nxt;

    assign at_end = &addr;

    // Decide whether the instruction completes this cycle and whether the input port is consumed.
    always_comb begin
        retire  = 1'b0;
        ack_raw = 1'b0;
        case (state)
            S_RUN:   retire = run_en && (op_class == OP_SINGLE);
            S_MULTI: retire = (cnt == '0);
            S_WAIT: begin
                retire  = in_valid;
                ack_raw = in_valid;
            end
            default: begin
                retire  = 1'b0;
                ack_raw = 1'b0;
            end
        endcase
    end

`ifdef PC_WRAP_EN
    // Retiring at the top address lets pcnt roll over to 0 and execution continues.
    assign inc_raw    = retire;
    assign retire_nxt = S_RUN;
`else
    // Retiring at the top address still writes back, but the PC parks there and the core halts.
    assign inc_raw    = retire & ~at_end;
    assign retire_nxt = at_end ? S_HALT : S_RUN;
`endif

    // Strobes are forced low during reset so an abandoned op never retires or acks.
    assign inc    = nRst & inc_raw;
    assign wr_en  = nRst & retire;
    assign in_ack = nRst & ack_raw;
    assign busy   = (state == S_MULTI) || (state == S_WAIT);
    assign halted = (state == S_HALT);

    // Sequencer state and multi-cycle countdown.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (run_en) begin
                        case (op_class)
                            OP_SINGLE: state <= retire_nxt;
                            OP_MULTI: begin
                                cnt   <= CNT_LOAD;
                                state <= S_MULTI;
                            end
                            OP_WAIT:  state <= S_WAIT;
                            OP_HALT:  state <= S_HALT;
                            default:  state <= S_RUN;
                        endcase
                    end
                end
                S_MULTI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= retire_nxt;
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        state <= retire_nxt;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: table-driven check of pc_seq with a small pcnt model closing the addr loop.
// Latency: one vector per clock; outputs sampled 2 time units after the falling-edge drive.
// Backpressure: none; expectations queued at drive time and popped at the sample point.
module tb_pc_seq;

    localparam int PW = 5;
`ifdef PC_WRAP_EN
    localparam logic W = 1'b1;
`else
    localparam logic W = 1'b0;
`endif

    logic          clk;
    logic          nRst;
    logic [PW-1:0] addr;
    logic [1:0]    op_class;
    logic          run_en;
    logic          in_valid;
    logic          in_ack;
    logic          inc;
    logic          wr_en;
    logic          busy;
    logic          halted;

    logic          ld;
    logic [PW-1:0] ld_val;

    int tests;
    int fails;

    typedef struct {
        logic          rst;
        logic [1:0]    op;
        logic          run;
        logic          iv;
        logic [4:0]    exp_o;    // {inc, wr_en, in_ack, busy, halted}
        logic [PW-1:0] exp_addr;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[29];

    pc_seq #(.PMEM_WIDTH(PW), .MUL_CYCLES(3)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .addr     (addr),
        .op_class (op_class),
        .run_en   (run_en),
        .in_valid (in_valid),
        .in_ack   (in_ack),
        .inc      (inc),
        .wr_en    (wr_en),
        .busy     (busy),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pcnt model: loadable program counter advanced by the DUT's inc strobe.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)    addr <= '0;
        else if (ld)  addr <= ld_val;
        else if (inc) addr <= addr + 1'b1;
    end

    function automatic vec_t v(input logic rst, input logic [1:0] op, input logic run,
                               input logic iv, input logic [4:0] eo, input logic [PW-1:0] ea);
        vec_t r;
        r.rst = rst; r.op = op; r.run = run; r.iv = iv; r.exp_o = eo; r.exp_addr = ea;
        return r;
    endfunction

    task automatic step(input vec_t x, input string name);
        vec_t e;
        logic [4:0] got;
        @(negedge clk);
        nRst     = x.rst;
        op_class = x.op;
        run_en   = x.run;
        in_valid = x.iv;
        sb_q.push_back(x);
        #2;
        e   = sb_q.pop_front();
        got = {inc, wr_en, in_ack, busy, halted};
        tests++;
        if (got !== e.exp_o) begin
            fails++;
            $display("FAIL %s outs{inc,wr,ack,busy,halt} got=%b exp=%b", name, got, e.exp_o);
        end
        tests++;
        if (addr !== e.exp_addr) begin
            fails++;
            $display("FAIL %s addr got=%0d exp=%0d", name, addr, e.exp_addr);
        end
    endtask

    task automatic load_pc(input logic [PW-1:0] val);
        @(negedge clk);
        nRst = 1'b1; run_en = 1'b0; in_valid = 1'b0; op_class = 2'b00;
        ld = 1'b1; ld_val = val;
        @(posedge clk);
        #1 ld = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        ld = 1'b0; ld_val = '0;
        op_class = 2'b00; run_en = 1'b1; in_valid = 1'b0;
        nRst = 1'b1;
        #1 nRst = 1'b0;

        //            rst op    run iv   inc/wr/ack/busy/halt  addr
        tbl[0]  = v(0, 2'd0, 1, 0, 5'b00000, 0);  // reset gates strobes
        tbl[1]  = v(0, 2'd0, 1, 0, 5'b00000, 0);
        tbl[2]  = v(1, 2'd0, 1, 0, 5'b11000, 0);  // singles
        tbl[3]  = v(1, 2'd0, 1, 0, 5'b11000, 1);
        tbl[4]  = v(1, 2'd0, 1, 0, 5'b11000, 2);
        tbl[5]  = v(1, 2'd0, 1, 0, 5'b11000, 3);
        tbl[6]  = v(1, 2'd1, 1, 0, 5'b00000, 4);  // multi: RUN cycle
        tbl[7]  = v(1, 2'd3, 0, 0, 5'b00010, 4);  // multi: inputs ignored
        tbl[8]  = v(1, 2'd3, 0, 0, 5'b11010, 4);  // multi: retire on 3rd cycle
        tbl[9]  = v(1, 2'd2, 1, 1, 5'b00000, 5);  // wait entry, in_valid early
        tbl[10] = v(1, 2'd0, 1, 0, 5'b00010, 5);
        tbl[11] = v(1, 2'd0, 1, 0, 5'b00010, 5);
        tbl[12] = v(1, 2'd0, 1, 0, 5'b00010, 5);
        tbl[13] = v(1, 2'd0, 1, 1, 5'b11110, 5);  // ack + retire
        tbl[14] = v(1, 2'd0, 0, 1, 5'b00000, 6);  // in_valid in RUN: no ack
        tbl[15] = v(1, 2'd0, 0, 1, 5'b00000, 6);  // run_en low: frozen
        tbl[16] = v(1, 2'd0, 0, 0, 5'b00000, 6);
        tbl[17] = v(1, 2'd1, 1, 0, 5'b00000, 6);  // multi start
        tbl[18] = v(0, 2'd1, 1, 0, 5'b00000, 0);  // reset on 2nd multi cycle
        tbl[19] = v(1, 2'd0, 1, 0, 5'b11000, 0);  // back in RUN
        tbl[20] = v(1, 2'd2, 1, 0, 5'b00000, 1);  // wait entry
        tbl[21] = v(0, 2'd0, 1, 1, 5'b00000, 0);  // reset mid-wait: no ack
        tbl[22] = v(1, 2'd0, 0, 1, 5'b00000, 0);
        tbl[23] = v(1, 2'd3, 1, 0, 5'b00000, 0);  // halt op
        tbl[24] = v(1, 2'd0, 1, 1, 5'b00001, 0);  // halt is sticky
        tbl[25] = v(1, 2'd1, 0, 0, 5'b00001, 0);
        tbl[26] = v(1, 2'd2, 1, 1, 5'b00001, 0);
        tbl[27] = v(0, 2'd0, 1, 0, 5'b00000, 0);  // only reset exits
        tbl[28] = v(1, 2'd0, 1, 0, 5'b11000, 0);

        for (int i = 0; i < 29; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Single op at the top address.
        load_pc(5'd30);
        step(v(1, 2'd0, 1, 0, 5'b11000, 30), "top_single_pre");
        step(v(1, 2'd0, 1, 0, {W, 4'b1000}, 31), "top_single");
        if (W) step(v(1, 2'd0, 1, 0, 5'b11000, 0), "top_single_after");
        else   step(v(1, 2'd0, 1, 0, 5'b00001, 31), "top_single_after");

        // Wait op at the top address: ack still fires.
        step(v(0, 2'd0, 0, 0, 5'b00000, 0), "top_wait_rst");
        load_pc(5'd31);
        step(v(1, 2'd2, 1, 0, 5'b00000, 31), "top_wait_enter");
        step(v(1, 2'd0, 0, 1, {W, 4'b1110}, 31), "top_wait_ack");
        if (W) step(v(1, 2'd0, 0, 0, 5'b00000, 0), "top_wait_after");
        else   step(v(1, 2'd0, 0, 0, 5'b00001, 31), "top_wait_after");

        // Multi op at the top address.
        step(v(0, 2'd0, 0, 0, 5'b00000, 0), "top_multi_rst");
        load_pc(5'd31);
        step(v(1, 2'd1, 1, 0, 5'b00000, 31), "top_multi_run");
        step(v(1, 2'd0, 0, 0, 5'b00010, 31), "top_multi_cnt");
        step(v(1, 2'd0, 0, 0, {W, 4'b1010}, 31), "top_multi_retire");
        if (W) step(v(1, 2'd0, 0, 0, 5'b00000, 0), "top_multi_after");
        else   step(v(1, 2'd0, 0, 0, 5'b00001, 31), "top_multi_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
